hazard_stall: RTL and testbench
===============================

// Module: hazard_stall
// PURPOSE
//  Interlock controller for the 5-stage pipeline; stalls where operand forwarding cannot resolve a hazard.
//  Covers load-use stalls, multi-cycle mult/div freezes (issue/wait/release FSM) and flushes on taken branches.
//  Sits beside the forwarding unit; drives PC, FD, DX and XM latch enables/bubble muxes and multdiv start pulses.
// PARAMETERS
//  MD_TIMEOUT  64  max BUSY cycles before a multdiv result is declared lost
//  CNT_W       32  width of perf counters (STALL_PERF_EN only)
// PORTS
//  clock          in   1   pipeline clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  fd_ir          in   32  instruction in FD latch
//  dx_ir          in   32  instruction in DX latch
//  branch_taken   in   1   DX-stage control transfer taken (bne/blt/j/jal/jr/bex)
//  md_rdy         in   1   multdiv result ready (single-cycle pulse)
//  stall_pc       out  1   hold PC
//  stall_fd       out  1   hold FD latch
//  stall_dx       out  1   hold DX latch
//  flush_fd       out  1   load nop into FD
//  bubble_dx      out  1   load nop into DX
//  bubble_xm      out  1   load nop into XM
//  ctrl_mult      out  1   one-cycle start pulse, multiply
//  ctrl_div       out  1   one-cycle start pulse, divide
//  md_sel         out  1   XM takes multdiv result instead of ALU
//  md_error       out  1   sticky: multdiv timeout occurred
// BEHAVIOUR
//  Decode: op=ir[31:27]; rd=[26:22], rs=[21:17], rt=[16:12]; R-type op 00000, ALU op [6:2]; mul 00110, div 00111.
//  Sources: R rs,rt; addi/lw rs; sw rs (addr), rd (data); bne/blt rd,rs; jr rd; bex r30; others none.
//  Reset low: FSM=IDLE, md_error=0, counters=0, all outputs 0 (outputs gated by reset).
//  Load-use: dx=lw, rd!=0, rd matches an fd source -> stall_pc=stall_fd=bubble_dx=1 for exactly 1 cycle.
//   Exception: match only on sw data field -> no stall (W->M bypass covers it).
//  FSM IDLE: dx=mul/div -> pulse ctrl_mult|ctrl_div this cycle, go BUSY; stall_pc/fd/dx=1, bubble_xm=1.
//  FSM BUSY: hold stalls + bubble_xm; cycle counter increments; md_rdy -> DONE; count==MD_TIMEOUT-1 -> set md_error, DONE.
//  FSM DONE (1 cycle): md_sel=1, no stalls, DX advances with result; -> IDLE. Back-to-back mul re-issues next cycle.
//  md_rdy in the same cycle as the start pulse: ignored (multdiv min latency >= 1 cycle).
//  md_rdy outside BUSY: ignored. Timeout result is garbage; md_sel still asserted so pipeline never deadlocks.
//  branch_taken: flush_fd=bubble_dx=1; overrides load-use stall (stall_* forced 0 so PC loads target).
//  branch_taken cannot coincide with mul/div in DX; if seen while BUSY it is ignored.
//  Reset mid-BUSY: immediate return to IDLE, no pulse; md_error cleared only by reset.
//  rd/r0: any dependency on r0 never stalls.
// CONFIGURATION
//  STALL_PERF_EN defined: adds ports perf_lu_cnt, perf_md_cnt, perf_br_cnt (out, CNT_W), each counting
//   load-use stall, multdiv stall, and flush cycles; saturate at all-ones, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared header isa_defs.vh: opcode/ALU-op constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BNE, OP_BLT,
//   OP_JR, OP_BEX, ALU_MUL, ALU_DIV), field-slice macros, REG_STATUS=30; also used by the forwarding unit.
//  FSM state encoding (ST_IDLE/ST_BUSY/ST_DONE) local to this module.
//  One sub-module md_tracker: IDLE/BUSY/DONE FSM, timeout counter, start pulses, md_sel, md_error.
//  Top level: combinational decode, load-use compare, priority merge, optional perf counters.
// TESTING
//  lw r5,0(r1) in DX; add r6,r5,r2 in FD -> stall_pc=stall_fd=bubble_dx=1 one cycle, then 0.
//  lw r5 in DX; sw r5,0(r3) in FD -> no stall; sw r3,0(r5) in FD -> stall 1 cycle.
//  mul r4,r2,r3 in DX, md_rdy after 17 cycles -> ctrl_mult pulse cycle 0, stalls 17 cycles, md_sel=1 cycle 18.
//  div, md_rdy never -> md_error=1 after MD_TIMEOUT cycles, DONE, IDLE; md_error stays 1 until reset.
//  branch_taken with lw r5 in DX and dependent op in FD -> flush_fd=bubble_dx=1, stall_pc=0.
//  reset low mid-BUSY -> all outputs 0 asynchronously; after release, new mul -> fresh pulse, normal timing.

Source files
------------

// File: rtl/hazard_stall_pkg.sv
// Shared ISA decode helpers for the pipeline interlock: opcode/ALU-op constants,
// instruction field slicing and per-opcode source-register usage.
package hazard_stall_pkg;

    localparam logic [4:0] OP_RTYPE   = 5'b00000;
    localparam logic [4:0] OP_BNE     = 5'b00010;
    localparam logic [4:0] OP_JR      = 5'b00100;
    localparam logic [4:0] OP_ADDI    = 5'b00101;
    localparam logic [4:0] OP_BLT     = 5'b00110;
    localparam logic [4:0] OP_SW      = 5'b00111;
    localparam logic [4:0] OP_LW      = 5'b01000;
    localparam logic [4:0] OP_BEX     = 5'b10110;

    localparam logic [4:0] ALU_MUL    = 5'b00110;
    localparam logic [4:0] ALU_DIV    = 5'b00111;

    localparam logic [4:0] REG_STATUS = 5'd30;

    // Which register fields an instruction reads. The sw data field (rd) is left
    // out on purpose: the W->M bypass covers it, so it never needs an interlock.
    typedef struct packed {
        logic rs;
        logic rt;
        logic rd;
        logic status;
    } src_use_t;

    function automatic logic [4:0] op_f(input logic [31:0] ir);
        return ir[31:27];
    endfunction

    function automatic logic [4:0] rd_f(input logic [31:0] ir);
        return ir[26:22];
    endfunction

    function automatic logic [4:0] rs_f(input logic [31:0] ir);
        return ir[21:17];
    endfunction

    function automatic logic [4:0] rt_f(input logic [31:0] ir);
        return ir[16:12];
    endfunction

    function automatic logic [4:0] alu_f(input logic [31:0] ir);
        return ir[6:2];
    endfunction

    function automatic src_use_t src_use(input logic [4:0] op);
        src_use_t u;
        u = '0;
        case (op)
            OP_RTYPE:               begin u.rs = 1'b1; u.rt = 1'b1; end
            OP_ADDI, OP_LW, OP_SW:  u.rs = 1'b1;
            OP_BNE, OP_BLT:         begin u.rd = 1'b1; u.rs = 1'b1; end
            OP_JR:                  u.rd = 1'b1;
            OP_BEX:                 u.status = 1'b1;
            default:                ;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/hazard_stall_md_tracker.sv
// Multdiv issue/wait/release tracker: start pulses, BUSY timeout counter,
// one-cycle md_sel on release and a sticky timeout error.
module hazard_stall_md_tracker #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic mul_i,
    input  logic div_i,
    input  logic md_rdy_i,
    output logic md_stall_o,
    output logic ctrl_mult_o,
    output logic ctrl_div_o,
    output logic md_sel_o,
    output logic md_error_o
);

    localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] CNT_LAST = TW'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

    state_e        state_q;
    logic [TW-1:0] cnt_q;
    logic          md_sel_q;
    logic          md_error_q;
    logic          issue;

    // The start pulse fires in the cycle the op sits in DX, before BUSY is entered.
    assign issue = (state_q == ST_IDLE) && (mul_i || div_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            md_sel_q   <= 1'b0;
            md_error_q <= 1'b0;
        end else begin
            md_sel_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (md_rdy_i) begin
                        state_q  <= ST_DONE;
                        md_sel_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        // Result is lost; still release so the pipeline cannot deadlock.
                        state_q    <= ST_DONE;
                        md_sel_q   <= 1'b1;
                        md_error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign md_stall_o  = issue || (state_q == ST_BUSY);
    assign ctrl_mult_o = issue && mul_i;
    assign ctrl_div_o  = issue && div_i && !mul_i;
    assign md_sel_o    = md_sel_q;
    assign md_error_o  = md_error_q;

endmodule

// File: rtl/hazard_stall.sv
// Pipeline interlock controller: load-use stalls, multdiv freezes and branch flushes.
// Define STALL_PERF_EN to add saturating perf counters for each stall/flush cause.
module hazard_stall
    import hazard_stall_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [31:0]       fd_ir_i,
    input  logic [31:0]       dx_ir_i,
    input  logic              branch_taken_i,
    input  logic              md_rdy_i,
`ifdef STALL_PERF_EN
    output logic [CNT_W-1:0]  perf_lu_cnt_o,
    output logic [CNT_W-1:0]  perf_md_cnt_o,
    output logic [CNT_W-1:0]  perf_br_cnt_o,
`endif
    output logic              stall_pc_o,
    output logic              stall_fd_o,
    output logic              stall_dx_o,
    output logic              flush_fd_o,
    output logic              bubble_dx_o,
    output logic              bubble_xm_o,
    output logic              ctrl_mult_o,
    output logic              ctrl_div_o,
    output logic              md_sel_o,
    output logic              md_error_o
);

    src_use_t   fd_use;
    logic [4:0] dx_rd;
    logic       lu_match;
    logic       dx_mul;
    logic       dx_div;
    logic       md_stall;
    logic       md_mult;
    logic       md_div;
    logic       md_sel;
    logic       md_error;
    logic       br_eff;
    logic       lu_eff;
    logic       unused_ir_bits;

    assign fd_use = src_use(op_f(fd_ir_i));
    assign dx_rd  = rd_f(dx_ir_i);

    // r0 is hardwired, so a load targeting it never creates a dependency.
    assign lu_match = (op_f(dx_ir_i) == OP_LW) && (dx_rd != 5'd0) &&
                      ((fd_use.rs     && (rs_f(fd_ir_i) == dx_rd)) ||
                       (fd_use.rt     && (rt_f(fd_ir_i) == dx_rd)) ||
                       (fd_use.rd     && (rd_f(fd_ir_i) == dx_rd)) ||
                       (fd_use.status && (dx_rd == REG_STATUS)));

    assign dx_mul = (op_f(dx_ir_i) == OP_RTYPE) && (alu_f(dx_ir_i) == ALU_MUL);
    assign dx_div = (op_f(dx_ir_i) == OP_RTYPE) && (alu_f(dx_ir_i) == ALU_DIV);

    assign unused_ir_bits = ^{fd_ir_i[11:0], dx_ir_i[21:7], dx_ir_i[1:0]};

    hazard_stall_md_tracker #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_md_tracker (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .mul_i       (dx_mul),
        .div_i       (dx_div),
        .md_rdy_i    (md_rdy_i),
        .md_stall_o  (md_stall),
        .ctrl_mult_o (md_mult),
        .ctrl_div_o  (md_div),
        .md_sel_o    (md_sel),
        .md_error_o  (md_error)
    );

    // Priority: multdiv freeze > taken branch > load-use. A branch drops the
    // load-use stall so the PC is free to load the target.
    assign br_eff = branch_taken_i && !md_stall;
    assign lu_eff = lu_match && !md_stall && !br_eff;

    assign stall_pc_o  = rst_ni && (md_stall || lu_eff);
    assign stall_fd_o  = rst_ni && (md_stall || lu_eff);
    assign stall_dx_o  = rst_ni && md_stall;
    assign flush_fd_o  = rst_ni && br_eff;
    assign bubble_dx_o = rst_ni && (br_eff || lu_eff);
    assign bubble_xm_o = rst_ni && md_stall;
    assign ctrl_mult_o = rst_ni && md_mult;
    assign ctrl_div_o  = rst_ni && md_div;
    assign md_sel_o    = rst_ni && md_sel;
    assign md_error_o  = rst_ni && md_error;

`ifdef STALL_PERF_EN
    logic [2:0] perf_evt;
    assign perf_evt = {br_eff, md_stall, lu_eff};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        assign cnt_d = (perf_evt[gi] && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign perf_lu_cnt_o = g_perf[0].cnt_q;
    assign perf_md_cnt_o = g_perf[1].cnt_q;
    assign perf_br_cnt_o = g_perf[2].cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall.sv
// Directed bench for hazard_stall: a per-cycle reference model derived from the
// interlock rules plus hand-computed literal checks at the interesting cycles.
module tb_hazard_stall;

    localparam int MD_TIMEOUT = 64;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [4:0] A_ADD   = 5'b00000;
    localparam logic [4:0] A_MUL   = 5'b00110;
    localparam logic [4:0] A_DIV   = 5'b00111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] fd_ir = '0;
    logic [31:0] dx_ir = '0;
    logic        br = 1'b0;
    logic        rdy = 1'b0;

    logic stall_pc, stall_fd, stall_dx, flush_fd, bubble_dx, bubble_xm;
    logic ctrl_mult, ctrl_div, md_sel, md_error;
    logic [9:0] outs;

`ifdef STALL_PERF_EN
    logic [31:0] perf_lu, perf_md, perf_br;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_stall #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (32)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fd_ir_i        (fd_ir),
        .dx_ir_i        (dx_ir),
        .branch_taken_i (br),
        .md_rdy_i       (rdy),
`ifdef STALL_PERF_EN
        .perf_lu_cnt_o  (perf_lu),
        .perf_md_cnt_o  (perf_md),
        .perf_br_cnt_o  (perf_br),
`endif
        .stall_pc_o     (stall_pc),
        .stall_fd_o     (stall_fd),
        .stall_dx_o     (stall_dx),
        .flush_fd_o     (flush_fd),
        .bubble_dx_o    (bubble_dx),
        .bubble_xm_o    (bubble_xm),
        .ctrl_mult_o    (ctrl_mult),
        .ctrl_div_o     (ctrl_div),
        .md_sel_o       (md_sel),
        .md_error_o     (md_error)
    );

    assign outs = {stall_pc, stall_fd, stall_dx, flush_fd, bubble_dx,
                   bubble_xm, ctrl_mult, ctrl_div, md_sel, md_error};

    function automatic logic [31:0] r_ins(input int rd, input int rs, input int rt, input logic [4:0] alu);
        return {OP_R, 5'(rd), 5'(rs), 5'(rt), 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] op, input int rd, input int rs);
        return {op, 5'(rd), 5'(rs), 17'd0};
    endfunction

    // Bitmask of registers an FD instruction depends on for a load-use interlock.
    function automatic logic [31:0] reads_mask(input logic [31:0] ir);
        logic [31:0] m;
        m = '0;
        case (ir[31:27])
            OP_R:                  begin m[ir[21:17]] = 1'b1; m[ir[16:12]] = 1'b1; end
            OP_ADDI, OP_LW, OP_SW: m[ir[21:17]] = 1'b1;
            OP_BNE, OP_BLT:        begin m[ir[26:22]] = 1'b1; m[ir[21:17]] = 1'b1; end
            OP_JR:                 m[ir[26:22]] = 1'b1;
            OP_BEX:                m[30] = 1'b1;
            default:               ;
        endcase
        return m;
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    // Reference model: multdiv progress tracked as issue cycle number + done flag.
    int cyc = 0;
    bit md_busy = 0;
    int md_issue = 0;
    bit md_done = 0;
    bit md_err = 0;

    always @(negedge clk) begin
        logic [9:0]  exp_v;
        logic [31:0] mask;
        logic        is_mul, is_div, issue, mdst, br_eff, lu, next_done;
        if (!rst_n) begin
            exp_v   = '0;
            md_busy = 0;
            md_done = 0;
            md_err  = 0;
        end else begin
            is_mul = (dx_ir[31:27] == OP_R) && (dx_ir[6:2] == A_MUL);
            is_div = (dx_ir[31:27] == OP_R) && (dx_ir[6:2] == A_DIV);
            issue  = !md_busy && !md_done && (is_mul || is_div);
            mdst   = issue || md_busy;
            br_eff = br && !mdst;
            mask   = reads_mask(fd_ir);
            lu     = (dx_ir[31:27] == OP_LW) && (dx_ir[26:22] != 5'd0) &&
                     mask[dx_ir[26:22]] && !mdst && !br_eff;
            exp_v  = {mdst | lu, mdst | lu, mdst, br_eff, br_eff | lu, mdst,
                      issue & is_mul, issue & is_div, md_done, md_err};
            next_done = 0;
            if (issue) begin
                md_busy  = 1;
                md_issue = cyc;
            end else if (md_busy && (rdy || (cyc - md_issue == MD_TIMEOUT))) begin
                if (!rdy) md_err = 1;
                md_busy   = 0;
                next_done = 1;
            end
            md_done = next_done;
        end
        check("cycle", outs, exp_v);
        cyc++;
    end

    task automatic step(input logic [31:0] f, input logic [31:0] d, input logic b, input logic r);
        @(posedge clk);
        #1;
        fd_ir = f;
        dx_ir = d;
        br    = b;
        rdy   = r;
    endtask

    logic [31:0] lw5, add65, mul, dv, dv2;

    initial begin
        lw5   = i_ins(OP_LW, 5, 1);
        add65 = r_ins(6, 5, 2, A_ADD);
        mul   = r_ins(4, 2, 3, A_MUL);
        dv    = r_ins(7, 2, 3, A_DIV);
        dv2   = r_ins(9, 7, 8, A_DIV);

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 check("reset outputs", outs, 10'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        $display("reset released");

        step(add65, lw5, 0, 0);
        #2 check("lu stall_pc", 10'(stall_pc), 10'd1);
        check("lu stall_fd", 10'(stall_fd), 10'd1);
        check("lu bubble_dx", 10'(bubble_dx), 10'd1);
        step(add65, 32'd0, 0, 0);
        #2 check("lu release", 10'({stall_pc, stall_fd, bubble_dx}), 10'd0);
        $display("load-use add: done");

        step(i_ins(OP_SW, 5, 3), lw5, 0, 0);
        #2 check("sw data no stall", 10'(stall_pc), 10'd0);
        step(i_ins(OP_SW, 3, 5), lw5, 0, 0);
        #2 check("sw addr stall", 10'(stall_pc), 10'd1);
        step(r_ins(6, 0, 0, A_ADD), i_ins(OP_LW, 0, 1), 0, 0);
        #2 check("r0 no stall", 10'(stall_pc), 10'd0);
        step(r_ins(6, 2, 5, A_ADD), lw5, 0, 0);
        #2 check("rt stall", 10'(bubble_dx), 10'd1);
        step(i_ins(OP_BNE, 5, 2), lw5, 0, 0);
        step(i_ins(OP_JR, 5, 0), lw5, 0, 0);
        step(i_ins(OP_BEX, 0, 0), i_ins(OP_LW, 30, 1), 0, 0);
        #2 check("bex r30 stall", 10'(stall_fd), 10'd1);
        step(i_ins(OP_J, 5, 5), lw5, 0, 0);
        #2 check("j no stall", 10'(stall_pc), 10'd0);
        step(i_ins(OP_ADDI, 7, 5), lw5, 0, 0);
        $display("source decode: done");

        step(add65, lw5, 1, 0);
        #2 check("br flush_fd", 10'(flush_fd), 10'd1);
        check("br bubble_dx", 10'(bubble_dx), 10'd1);
        check("br stall_pc", 10'(stall_pc), 10'd0);
        step(32'd0, 32'd0, 0, 0);
        $display("branch over load-use: done");

        for (int c = 0; c < 19; c++) begin
            step(32'd0, mul, (c == 5), (c == 0) || (c == 17));
            #2;
            if (c == 0)  check("mul pulse", 10'(ctrl_mult), 10'd1);
            if (c == 17) check("mul last stall", 10'(stall_pc), 10'd1);
            if (c == 18) check("mul md_sel", 10'({md_sel, stall_pc}), 10'b10);
        end
        step(32'd0, dv, 0, 0);
        #2 check("b2b div pulse", 10'(ctrl_div), 10'd1);
        step(32'd0, dv, 0, 1);
        step(32'd0, dv, 0, 0);
        #2 check("div md_sel", 10'(md_sel), 10'd1);
        step(32'd0, 32'd0, 0, 1);
        $display("mul 17 + back-to-back div: done");

        for (int c = 0; c < 67; c++) begin
            step(32'd0, (c < 66) ? dv2 : 32'd0, 0, 0);
            #2;
            if (c == 64) check("timeout pre err", 10'(md_error), 10'd0);
            if (c == 65) check("timeout done", 10'({md_sel, md_error}), 10'b11);
            if (c == 66) check("timeout sticky", 10'({md_error, stall_pc}), 10'b10);
        end
        $display("div timeout: done");

        for (int c = 0; c < 5; c++) step(32'd0, mul, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("async reset", outs, 10'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("fresh pulse", 10'({ctrl_mult, stall_dx}), 10'b11);
        step(32'd0, mul, 0, 0);
        step(32'd0, mul, 0, 1);
        step(32'd0, mul, 0, 0);
        #2 check("post-reset md_sel", 10'({md_sel, md_error}), 10'b10);
        step(32'd0, 32'd0, 0, 0);
        step(32'd0, 32'd0, 0, 0);
        $display("reset mid-busy: done");

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
